// File: rtl/conv2d_stream_k_if.sv
// Handshake bundle for conv2d_stream_k: weight load port, pixel stream in, result stream out.
interface conv2d_stream_k_if #(
  parameter int DW = 16
) ();
  logic                 w_load;
  logic signed [DW-1:0] w_data;
  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] map_in;
  logic signed [DW-1:0] map_out;
  logic                 save;
  logic                 ready;

  modport master (output w_load, w_data, start, in_valid, map_in,
                  input  map_out, save, ready);
  modport slave  (input  w_load, w_data, start, in_valid, map_in,
                  output map_out, save, ready);
endinterface

// File: rtl/conv2d_stream_k.sv
// Streaming KxK "valid" convolution with runtime-loaded weights/bias, round half-up,
// saturation and optional ReLU. Three-cycle pipeline: multiply, adder tree, post-process.
module conv2d_stream_k #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int K     = 9,
  parameter int DW    = 16,
  parameter int FRAC  = 12,
  parameter int ACC_W = 40,
  parameter int RELU  = 0
) (
  input  logic clk_in,
  input  logic rst_n,
  conv2d_stream_k_if.slave bus
);
  // state | meaning
  // IDLE  | weights loadable, waiting for start
  // RUN   | accepting pixels, producing windows
  // DONE  | all NOUT results delivered, waiting for start to fall
  localparam int NTAP  = K * K;
  localparam int DEPTH = (K - 1) * IMG_W + K;
  localparam int NOUT  = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int PW    = $clog2(NTAP + 1);
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int OW    = $clog2(NOUT + 1);
  localparam logic signed [ACC_W-1:0] RND  = (FRAC > 0) ? (ACC_W'(1) << (FRAC - 1)) : '0;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic signed [DW-1:0] wt [NTAP];
  logic signed [DW-1:0] bias;
  logic [PW-1:0]        wptr;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [OW-1:0]        out_cnt;
  logic                 v0, v1, v2;
  logic signed [DW-1:0] map_out_r;
  logic                 save_r, ready_r;

  logic signed [DW-1:0]    lb [DEPTH];
  logic signed [2*DW-1:0]  prod [NTAP];
  logic signed [ACC_W-1:0] sum_c, sum_r;
  logic signed [ACC_W-1:0] bias_sh, rnd_c, shr_c;
  logic signed [DW-1:0]    res_c;
  logic                    accept, win_ok;

  assign accept = bus.in_valid && (state == RUN) && (row < RW'(IMG_H));
  assign win_ok = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

  assign bus.map_out = map_out_r;
  assign bus.save    = save_r;
  assign bus.ready   = ready_r;

  // lb[0] is the newest pixel; window tap (i,j) sits (K-1-i) rows and (K-1-j) columns back.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      lb[0] <= bus.map_in;
      for (int i = 1; i < DEPTH; i++) lb[i] <= lb[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        prod[i*K+j] <= wt[i*K+j] * lb[(K-1-i)*IMG_W + (K-1-j)];
    sum_r <= sum_c;
  end

  always_comb begin
    sum_c = '0;
    for (int t = 0; t < NTAP; t++)
      sum_c = sum_c + {{(ACC_W-2*DW){prod[t][2*DW-1]}}, prod[t]};
  end

  always_comb begin
    bias_sh = {{(ACC_W-DW){bias[DW-1]}}, bias};
    bias_sh = bias_sh <<< FRAC;
    rnd_c   = sum_r + bias_sh + RND;
    shr_c   = rnd_c >>> FRAC;
    if (shr_c > MAXV)      res_c = {1'b0, {(DW-1){1'b1}}};
    else if (shr_c < MINV) res_c = {1'b1, {(DW-1){1'b0}}};
    else                   res_c = shr_c[DW-1:0];
    if (RELU != 0 && res_c[DW-1]) res_c = '0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int s = 0; s < NTAP; s++) wt[s] <= '0;
      bias      <= '0;
      wptr      <= '0;
      col       <= '0;
      row       <= '0;
      out_cnt   <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      map_out_r <= '0;
      save_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      save_r <= 1'b0;
      v0     <= accept && win_ok;
      v1     <= v0;
      v2     <= v1;
      case (state)
        IDLE: begin
          if (bus.w_load) begin
            for (int s = 0; s < NTAP; s++)
              if (wptr == PW'(s)) wt[s] <= bus.w_data;
            if (wptr == PW'(NTAP)) begin
              bias <= bus.w_data;
              wptr <= '0;
            end else begin
              wptr <= wptr + PW'(1);
            end
          end
          if (bus.start) begin
            state <= RUN;
            wptr  <= '0;
          end
        end
        RUN: begin
          if (out_cnt == OW'(NOUT)) begin
            state   <= DONE;
            ready_r <= 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (v2 && state == RUN) begin
        save_r    <= 1'b1;
        map_out_r <= res_c;
        out_cnt   <= out_cnt + OW'(1);
      end
      // start low squashes everything in flight, including a save due this edge.
      if (!bus.start) begin
        state     <= IDLE;
        ready_r   <= 1'b1;
        v0        <= 1'b0;
        v1        <= 1'b0;
        v2        <= 1'b0;
        save_r    <= 1'b0;
        map_out_r <= '0;
        col       <= '0;
        row       <= '0;
        out_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv2d_stream_k.sv
// Scoreboard bench for conv2d_stream_k: a RELU=0 and a RELU=1 instance run in lockstep
// on the same stimulus; expected results are queued at drive time and popped on save.
module tb_conv2d_stream_k;
  localparam int W = 6, H = 5, K = 3, DW = 16, FRAC = 12;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  conv2d_stream_k_if #(.DW(DW)) b0 ();
  conv2d_stream_k_if #(.DW(DW)) b1 ();

  assign b1.w_load   = b0.w_load;
  assign b1.w_data   = b0.w_data;
  assign b1.start    = b0.start;
  assign b1.in_valid = b0.in_valid;
  assign b1.map_in   = b0.map_in;

  conv2d_stream_k #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW), .FRAC(FRAC), .ACC_W(40), .RELU(0))
    dut0 (.clk_in(clk_in), .rst_n(rst_n), .bus(b0));
  conv2d_stream_k #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW), .FRAC(FRAC), .ACC_W(40), .RELU(1))
    dut1 (.clk_in(clk_in), .rst_n(rst_n), .bus(b1));

  typedef struct {int v0; int v1; int cyc;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0, nsave = 0;
  int img [H][W];
  int wt [K*K];
  int bias;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model(int r, int c, bit relu);
    longint acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += longint'(wt[i*K+j]) * longint'(img[r-K+1+i][c-K+1+j]);
    acc += longint'(bias) * (longint'(1) << FRAC);
    acc += longint'(1) << (FRAC - 1);
    acc = acc >>> FRAC;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  always @(negedge clk_in) begin
    if (b0.save === 1'b1 || b1.save === 1'b1) begin
      if (sb.size() == 0) begin
        chk("save_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("map_out", b0.map_out, e.v0);
        chk("map_out_relu", b1.map_out, e.v1);
        chk("save_both", {b0.save, b1.save}, 2'b11);
        chk("save_latency", cyc, e.cyc);
      end
      nsave++;
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic fill_img(input bit rnd, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rnd ? int'($signed(16'($urandom))) : val;
  endtask

  task automatic set_wt(input int val, input int b);
    for (int i = 0; i < K*K; i++) wt[i] = val;
    bias = b;
  endtask

  // Loads K*K weights then bias; optionally raises start on the bias-write edge.
  task automatic load_w(input bit st);
    for (int i = 0; i <= K*K; i++) begin
      step();
      b0.w_load = 1'b1;
      b0.w_data = 16'((i < K*K) ? wt[i] : bias);
      if (i == K*K && st) b0.start = 1'b1;
    end
    step();
    b0.w_load = 1'b0;
  endtask

  task automatic run_frame(input bit gapped, input bit noise, input int abort_after, input int rst_at);
    int base;
    bit v;
    base = nsave;
    if (!b0.start) begin
      step();
      b0.start = 1'b1;
    end
    step();
    chk("ready_run", b0.ready, 1);
    for (int p = 0; p < W*H; p++) begin
      int r, c;
      r = p / W;
      c = p % W;
      do begin
        step();
        if (abort_after > 0 && nsave - base >= abort_after) begin
          b0.start = 1'b0;
          b0.in_valid = 1'b0;
          sb.delete();
          step();
          chk("abort_save", b0.save, 0);
          chk("abort_ready", b0.ready, 1);
          chk("abort_map_out", b0.map_out, 0);
          repeat (6) step();
          chk("abort_save_count", nsave - base, abort_after);
          chk("idle_ready", b1.ready, 1);
          return;
        end
        if (rst_at == p) begin
          rst_n = 1'b0;
          b0.start = 1'b0;
          b0.in_valid = 1'b0;
          b0.w_load = 1'b0;
          sb.delete();
          step();
          chk("rst_save", b0.save, 0);
          chk("rst_ready", b0.ready, 1);
          chk("rst_map_out", b0.map_out, 0);
          rst_n = 1'b1;
          set_wt(0, 0);
          return;
        end
        v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
        b0.in_valid = v;
        b0.map_in = 16'(img[r][c]);
        if (noise) begin
          b0.w_load = 1'($urandom_range(0, 1));
          b0.w_data = 16'($urandom);
        end
      end while (!v);
      if (r >= K-1 && c >= K-1)
        sb.push_back('{model(r, c, 1'b0), model(r, c, 1'b1), cyc + 4});
    end
    step();
    b0.in_valid = 1'b0;
    b0.w_load = 1'b0;
    if (abort_after > 0) chk("abort_reached", 0, 1);
    repeat (8) step();
    chk("frame_saves", nsave - base, (W-K+1)*(H-K+1));
    chk("ready_done", b0.ready, 0);
    chk("ready_done_relu", b1.ready, 0);
    chk("sb_empty", sb.size(), 0);
    b0.start = 1'b0;
    step();
    chk("ready_idle", b0.ready, 1);
  endtask

  initial begin
    b0.w_load = 1'b0;
    b0.w_data = '0;
    b0.start = 1'b0;
    b0.in_valid = 1'b0;
    b0.map_in = '0;
    repeat (3) step();
    chk("rst_map_out", b0.map_out, 0);
    chk("rst_save", b0.save, 0);
    chk("rst_ready", b0.ready, 1);
    rst_n = 1'b1;

    // gain: bias written on the same edge that starts the frame
    set_wt(4096, 0);
    fill_img(1'b0, 1);
    load_w(1'b1);
    run_frame(1'b0, 1'b0, 0, -1);

    // rounding
    set_wt(0, 0);
    wt[4] = 2048;
    fill_img(1'b0, 3);
    load_w(1'b0);
    run_frame(1'b0, 1'b0, 0, -1);
    fill_img(1'b0, -3);
    run_frame(1'b0, 1'b0, 0, -1);
    bias = 5;
    fill_img(1'b0, 3);
    load_w(1'b1);
    run_frame(1'b0, 1'b0, 0, -1);

    // saturation, both polarities (RELU instance clamps negative)
    set_wt(32767, 0);
    fill_img(1'b0, 32767);
    load_w(1'b0);
    run_frame(1'b0, 1'b0, 0, -1);
    fill_img(1'b0, -32768);
    run_frame(1'b0, 1'b0, 0, -1);

    // gapped input
    set_wt(4096, 0);
    fill_img(1'b0, 1);
    load_w(1'b0);
    run_frame(1'b1, 1'b0, 0, -1);

    // random weights/bias/pixels, gapped
    for (int i = 0; i < K*K; i++) wt[i] = int'($urandom_range(0, 8192)) - 4096;
    bias = int'($urandom_range(0, 200)) - 100;
    fill_img(1'b1, 0);
    load_w(1'b0);
    run_frame(1'b1, 1'b0, 0, -1);

    // abort after 4th save, then full restart with retained weights
    set_wt(4096, 0);
    fill_img(1'b0, 1);
    load_w(1'b0);
    run_frame(1'b0, 1'b0, 4, -1);
    run_frame(1'b0, 1'b0, 0, -1);

    // w_load noise during RUN is ignored
    run_frame(1'b0, 1'b1, 0, -1);

    // reset mid-frame clears weights; restart without reload gives zeros
    run_frame(1'b0, 1'b0, 0, 20);
    fill_img(1'b0, 7);
    run_frame(1'b0, 1'b0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv2d_stream_k.md
# conv2d_stream_k

Parametrised streaming 2-D convolution engine for one input feature map and one output channel. It is the generic successor of the fixed 9x9 / 96-column convolution stages. Kernel size, image geometry, fixed-point format, bias and ReLU are all parameters or runtime-loaded values. Unlike the fixed stages, weights and bias are loaded at runtime through a serial port, and input pixels are qualified by a valid strobe. It sits between the frame buffer read-out and the pooling stage, and its map_out/save/ready handshake is unchanged for downstream blocks.

## Interface
- IMG_W, 100: input row length in pixels
- IMG_H, 100: input row count
- K, 9: square kernel size (2..11)
- DW, 16: signed pixel, weight, bias and output width
- FRAC, 12: fractional bits of weights (Q(DW-FRAC).FRAC)
- ACC_W, 40: accumulator width, must be at least 2*DW+ceil(log2(K*K))+1
- RELU, 0: 1 clamps negative outputs to 0
- clk_in  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- w_load  in  1  weight/bias write strobe (accepted in IDLE only)
- w_data  in  DW  signed weight word; K*K weights row-major, then bias
- start  in  1  level; high = frame active; low = abort/idle
- in_valid  in  1  map_in qualifier
- map_in  in  DW  signed pixel, raster order
- map_out  out  DW  signed result, valid when save=1
- save  out  1  output strobe, one per valid window
- ready  out  1  1 = frame not finished; 0 = all outputs delivered

## Operation
- State machine:
  - IDLE -> RUN when start=1.
  - RUN -> DONE when the output counter reaches NOUT=(IMG_W-K+1)*(IMG_H-K+1).
  - RUN or DONE -> IDLE whenever start=0 is sampled.
- Weight load:
  - In IDLE, each w_load=1 cycle writes w_data to slot wptr, then increments wptr.
  - Slots 0..K*K-1 are weights; slot K*K is the bias. wptr wraps to 0 after the bias.
  - wptr clears on reset and on leaving IDLE. w_load outside IDLE is ignored.
  - Weights and bias persist across frames.
- Pixel path:
  - Each accepted pixel (in_valid=1 in RUN) shifts a (K-1)*IMG_W+K deep line buffer and a KxK window register.
  - col and row counters advance; col wraps at IMG_W-1 and increments row.
- A window is valid when row>=K-1 and col>=K-1 at acceptance. Output is a "valid" convolution with no padding.
- Arithmetic:
  - acc = sum of w[i][j]*pix[i][j], full precision in ACC_W bits.
  - Add bias<<FRAC.
  - Round half-up: add 1<<(FRAC-1), then arithmetic shift right by FRAC.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - If RELU=1, force negative results to 0.
- Pixels with in_valid=1 in IDLE or DONE are ignored.
- After the NOUT-th save, further pixels are ignored until start falls.
- Reset values:
  - map_out=0, save=0, ready=1.
  - State IDLE; counters, wptr, weights and bias = 0.
  - Line-buffer contents are don't-care.

## Timing
- Pipeline:
  - Edge t: pixel accepted, window updated.
  - t+1: products registered.
  - t+2: adder-tree sum registered.
  - t+3: bias, round, saturate and ReLU applied; map_out/save registered.
- Latency is exactly 3 cycles from acceptance of the window-completing pixel.
- The pipeline never stalls. Bubbles from in_valid=0 travel as invalid tags.
- save is a single-cycle pulse per window. Back-to-back pulses occur for consecutive valid pixels.
- map_out holds its last value when save=0, and is 0 after reset or abort.
- ready drops to 0 on the edge after the NOUT-th save. It stays 0 in DONE and returns to 1 on the edge that enters IDLE.
- Abort when start is sampled low:
  - On that edge: all in-flight tags squashed, save=0, map_out=0, counters cleared.
  - Any save scheduled later is suppressed.
- Reset mid-frame has the same effect as abort, and also clears weights.
- If start=1 and w_load=1 on the same edge in IDLE, the write happens and the state enters RUN.

## Test plan
- Test configuration: IMG_W=6, IMG_H=5, K=3, FRAC=12.
- Gain and count: all 9 weights 4096, bias 0, every pixel 1, in_valid=1 every cycle -> 12 saves, each map_out=9; first save 3 cycles after pixel index 14 is accepted; ready=0 after the 12th save.
- Rounding: only the centre weight is 2048, bias 0, all pixels 3 -> map_out=2. All pixels -3 -> map_out=-1. Bias=5 with pixels 3 -> map_out=7.
- Saturation and ReLU: all weights 32767 and all pixels 32767 -> map_out=32767. Pixels -32768 -> map_out=-32768. Same negative case with RELU=1 -> map_out=0.
- Gapped input: pseudo-random in_valid with 50% duty, gain-test data -> same 12 values in the same order; each save 3 cycles after its completing pixel.
- Abort and restart: drop start after the 4th save -> save=0 from that edge on, and ready=1 in IDLE. Re-raise start and send the full frame -> 12 outputs, with weights retained.
- Load discipline: w_load pulses during RUN do not change results. Reset asserted mid-frame -> save=0, ready=1, and all outputs are 0 after restart without a reload.
